// File: rtl/mips_cpu.sv
// mips_cpu: five-stage pipelined MIPS subset core (IF/ID/EX/MEM/WB) with internal memories.
// Define MIPS_CPU_TRACE_EN to print committed register writes and stores.
module mips_cpu (
    input logic clk,
    input logic reset
);
    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;
    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [1:0]  op;
        logic        src_imm;
        logic        load;
        logic        store;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } idex_t;
    typedef struct packed {
        logic [4:0]  dest;
        logic        load;
        logic        store;
        logic [31:0] res;
        logic [31:0] wdata;
    } exmem_t;
    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } memwb_t;

    // Declaration initialisers give the post-reset state at time zero; dest 0 means no write.
    logic [31:0] imem [1024] = '{default: '0};
    logic [31:0] dmem_q [1024] = '{default: '0};
    logic [31:0] rf_q [32] = '{default: '0};
    logic [31:0] pc_q = 32'h0000_3000;
    ifid_t ifid_q = '0;
    idex_t idex_q = '0;
    exmem_t exmem_q = '0;
    memwb_t memwb_q = '0;
    logic [31:0] pc_d;
    ifid_t ifid_d;
    idex_t idex_d;
    exmem_t exmem_d;
    memwb_t memwb_d;

    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] sext, pc4, rs_v, rt_v, target;
    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic use_rs, use_rt, is_br, ex_hit, mem_hit, stall, taken;
    logic [31:0] ex_a, ex_b, ex_op2, mem_rdata;

    function automatic logic [31:0] id_read(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (r == exmem_q.dest && !exmem_q.load) return exmem_q.res;
        if (r == memwb_q.dest) return memwb_q.data;
        return rf_q[r];
    endfunction

    function automatic logic [31:0] ex_read(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0 && r == exmem_q.dest && !exmem_q.load) return exmem_q.res;
        if (r != 5'd0 && r == memwb_q.dest) return memwb_q.data;
        return v;
    endfunction

    // The 0x3000 base has zero low bits, so the word index is just pc[11:2].
    always_comb begin
        ifid_d = stall ? ifid_q : '{pc: pc_q, instr: imem[pc_q[11:2]]};
        pc_d = stall ? pc_q : taken ? target : pc_q + 32'd4;
    end

    assign op = ifid_q.instr[31:26];
    assign rs = ifid_q.instr[25:21];
    assign rt = ifid_q.instr[20:16];
    assign rd = ifid_q.instr[15:11];
    assign fn = ifid_q.instr[5:0];
    assign imm16 = ifid_q.instr[15:0];
    assign sext = {{16{imm16[15]}}, imm16};
    assign pc4 = ifid_q.pc + 32'd4;
    assign is_addu = op == 6'h00 && fn == 6'h21;
    assign is_subu = op == 6'h00 && fn == 6'h23;
    assign is_jr = op == 6'h00 && fn == 6'h08;
    assign is_ori = op == 6'h0d;
    assign is_lui = op == 6'h0f;
    assign is_lw = op == 6'h23;
    assign is_sw = op == 6'h2b;
    assign is_beq = op == 6'h04;
    assign is_j = op == 6'h02;
    assign is_jal = op == 6'h03;
    assign use_rs = is_addu || is_subu || is_jr || is_ori || is_lw || is_sw || is_beq;
    assign use_rt = is_addu || is_subu || is_sw || is_beq;
    assign is_br = is_beq || is_jr;
    assign rs_v = id_read(rs);
    assign rt_v = id_read(rt);

    // A branch behind a load in EX stalls here, then again through mem_hit: two cycles total.
    assign ex_hit = idex_q.dest != 5'd0 && ((use_rs && rs == idex_q.dest) || (use_rt && rt == idex_q.dest));
    assign mem_hit = exmem_q.dest != 5'd0 && ((use_rs && rs == exmem_q.dest) || (use_rt && rt == exmem_q.dest));
    assign stall = (ex_hit && (idex_q.load || is_br)) || (mem_hit && exmem_q.load && is_br);
    assign taken = is_j || is_jal || is_jr || (is_beq && rs_v == rt_v);
    assign target = is_beq ? pc4 + {sext[29:0], 2'b00} : is_jr ? rs_v : {pc4[31:28], ifid_q.instr[25:0], 2'b00};

    always_comb begin
        idex_d = '0;
        if (!stall) begin
            idex_d.rs = rs;
            idex_d.rt = rt;
            idex_d.dest = (is_addu || is_subu) ? rd : (is_ori || is_lui || is_lw) ? rt : is_jal ? 5'd31 : 5'd0;
            idex_d.op = is_subu ? ALU_SUB : is_ori ? ALU_OR : (is_lui || is_jal) ? ALU_PASS : ALU_ADD;
            idex_d.src_imm = is_ori || is_lui || is_lw || is_sw || is_jal;
            idex_d.load = is_lw;
            idex_d.store = is_sw;
            idex_d.a = rs_v;
            idex_d.b = rt_v;
            idex_d.imm = is_ori ? {16'h0, imm16} : is_lui ? {imm16, 16'h0} : is_jal ? pc4 + 32'd4 : sext;
        end
    end

    assign ex_a = ex_read(idex_q.rs, idex_q.a);
    assign ex_b = ex_read(idex_q.rt, idex_q.b);
    assign ex_op2 = idex_q.src_imm ? idex_q.imm : ex_b;

    always_comb begin
        exmem_d.dest = idex_q.dest;
        exmem_d.load = idex_q.load;
        exmem_d.store = idex_q.store;
        exmem_d.wdata = ex_b;
        exmem_d.res = idex_q.op == ALU_ADD ? ex_a + ex_op2 :
                      idex_q.op == ALU_SUB ? ex_a - ex_op2 :
                      idex_q.op == ALU_OR ? ex_a | ex_op2 : ex_op2;
    end

    assign mem_rdata = dmem_q[exmem_q.res[11:2]];
    assign memwb_d = '{dest: exmem_q.dest, data: exmem_q.load ? mem_rdata : exmem_q.res};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 32'h0000_3000;
            ifid_q <= '0;
            idex_q <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            ifid_q <= ifid_d;
            idex_q <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            if (memwb_q.dest != 5'd0) rf_q[memwb_q.dest] <= memwb_q.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && exmem_q.store) dmem_q[exmem_q.res[11:2]] <= exmem_q.wdata;
    end

`ifdef MIPS_CPU_TRACE_EN
    logic [31:0] ex_pc_q = '0;
    logic [31:0] mem_pc_q = '0;
    logic [31:0] wb_pc_q = '0;

    always_ff @(posedge clk) begin
        ex_pc_q <= (reset || stall) ? '0 : ifid_q.pc;
        mem_pc_q <= reset ? '0 : ex_pc_q;
        wb_pc_q <= reset ? '0 : mem_pc_q;
        if (!reset && memwb_q.dest != 5'd0) $display("@%08h: $%0d <= %08h", wb_pc_q, memwb_q.dest, memwb_q.data);
        if (!reset && exmem_q.store) $display("@%08h: *%08h <= %08h", mem_pc_q, exmem_q.res, exmem_q.wdata);
    end
`endif
endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: scoreboard bench; programs are written into the instruction memory through hierarchy
// and every register write / store is matched against queued expectations (register, value, cycle).
module tb_mips_cpu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        logic [31:0] key;
        logic [31:0] val;
    } exp_t;
    exp_t wr_q[$];
    exp_t st_q[$];

    mips_cpu dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] word);
        return {op, word};
    endfunction

    task automatic load(input int i, input logic [31:0] w);
        dut.imem[i] = w;
    endtask

    task automatic exp_wr(input int c, input logic [4:0] r, input logic [31:0] v);
        wr_q.push_back('{c, {27'd0, r}, v});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (dut.memwb_q.dest != 5'd0) begin
            if (wr_q.size() == 0) check("unexpected_wr", {27'd0, dut.memwb_q.dest}, 32'd0);
            else begin
                e = wr_q.pop_front();
                check($sformatf("wr_r%0d_rd", e.key), {27'd0, dut.memwb_q.dest}, e.key);
                check($sformatf("wr_r%0d_val", e.key), dut.memwb_q.data, e.val);
                check($sformatf("wr_r%0d_cyc", e.key), cyc, e.cyc);
            end
        end
        if (dut.exmem_q.store) begin
            if (st_q.size() == 0) check("unexpected_st", dut.exmem_q.res, 32'hffff_ffff);
            else begin
                e = st_q.pop_front();
                check("st_addr", dut.exmem_q.res, e.key);
                check("st_data", dut.exmem_q.wdata, e.val);
                check("st_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        @(negedge clk);
        load(0, i_op(6'h0d, 0, 1, 16'h1234));
        load(1, i_op(6'h0f, 0, 2, 16'habcd));
        load(2, r_op(1, 2, 3, 6'h21));
        load(3, i_op(6'h2b, 0, 3, 16'h0004));
        load(4, i_op(6'h23, 0, 4, 16'h0004));
        load(5, r_op(4, 4, 5, 6'h21));
        load(6, i_op(6'h0d, 0, 6, 16'h0005));
        load(7, i_op(6'h04, 6, 6, 16'h0002));
        load(8, i_op(6'h0d, 0, 7, 16'h0001));
        load(9, i_op(6'h0d, 0, 8, 16'h0001));
        load(10, i_op(6'h0d, 0, 9, 16'h0001));
        load(11, j_op(6'h03, 26'h0000c14));
        load(12, i_op(6'h0d, 0, 10, 16'h0003));
        load(13, i_op(6'h0d, 0, 11, 16'h0004));
        load(14, i_op(6'h0d, 0, 0, 16'h0007));
        load(15, r_op(0, 0, 1, 6'h21));
        load(16, i_op(6'h0d, 0, 13, 16'h0001));
        load(17, r_op(0, 13, 12, 6'h23));
        load(18, j_op(6'h02, 26'h0000c12));
        load(19, 32'h0);
        load(20, i_op(6'h0d, 0, 14, 16'h0009));
        load(21, r_op(31, 0, 0, 6'h08));
        load(22, i_op(6'h0d, 0, 15, 16'h0006));
        exp_wr(4, 1, 32'h0000_1234);
        exp_wr(5, 2, 32'habcd_0000);
        exp_wr(6, 3, 32'habcd_1234);
        exp_wr(8, 4, 32'habcd_1234);
        exp_wr(10, 5, 32'h579a_2468);
        exp_wr(11, 6, 32'd5);
        exp_wr(14, 7, 32'd1);
        exp_wr(15, 9, 32'd1);
        exp_wr(16, 31, 32'h0000_3034);
        exp_wr(17, 10, 32'd3);
        exp_wr(18, 14, 32'd9);
        exp_wr(20, 15, 32'd6);
        exp_wr(21, 11, 32'd4);
        exp_wr(23, 1, 32'd0);
        exp_wr(24, 13, 32'd1);
        exp_wr(25, 12, 32'hffff_ffff);
        st_q.push_back('{6, 32'd4, 32'habcd_1234});
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("a_wr_drain", wr_q.size(), 0);
        check("a_st_drain", st_q.size(), 0);
        check("a_r0", dut.rf_q[0], 32'd0);
        check("a_r1", dut.rf_q[1], 32'd0);
        check("a_r8", dut.rf_q[8], 32'd0);
        check("a_r31", dut.rf_q[31], 32'h0000_3034);
        check("a_r12", dut.rf_q[12], 32'hffff_ffff);
        check("a_dm1", dut.dmem_q[1], 32'habcd_1234);

        load(0, i_op(6'h23, 0, 4, 16'h0004));
        load(1, i_op(6'h04, 4, 4, 16'h0002));
        load(2, i_op(6'h0d, 0, 7, 16'h0002));
        load(3, i_op(6'h0d, 0, 8, 16'h0003));
        load(4, i_op(6'h0d, 0, 9, 16'h0004));
        load(5, j_op(6'h02, 26'h0000c05));
        load(6, 32'h0);
        exp_wr(4, 4, 32'habcd_1234);
        exp_wr(8, 7, 32'd2);
        exp_wr(9, 9, 32'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_pc", dut.pc_q, 32'h0000_3000);
        check("rst_r3", dut.rf_q[3], 32'd0);
        check("rst_r31", dut.rf_q[31], 32'd0);
        check("rst_dm1", dut.dmem_q[1], 32'habcd_1234);
        repeat (20) @(negedge clk);
        check("b_wr_drain", wr_q.size(), 0);
        check("b_r4", dut.rf_q[4], 32'habcd_1234);
        check("b_r7", dut.rf_q[7], 32'd2);
        check("b_r8", dut.rf_q[8], 32'd0);
        check("b_r9", dut.rf_q[9], 32'd4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
